// File: rtl/bcd_countdown_timer_pkg.sv
// Shared types, widths and clamp helpers for the MM:SS BCD countdown timer.
// Optional feature macro used by the top: COUNTDOWN_AUTO_RELOAD_EN.
package bcd_countdown_timer_pkg;

    localparam int BCD_BIT_WIDTH = 4;
    localparam int NUM_DIGITS    = 4;
    localparam int TIME_WIDTH    = NUM_DIGITS * BCD_BIT_WIDTH;

    typedef logic [BCD_BIT_WIDTH-1:0] bcd_t;
    typedef logic [TIME_WIDTH-1:0]    bcd_time_t;

    typedef enum logic [1:0] {
        CD_IDLE  = 2'd0,
        CD_RUN   = 2'd1,
        CD_PAUSE = 2'd2,
        CD_DONE  = 2'd3
    } cd_state_t;

    localparam bcd_t      BCD_ZERO  = 4'd0;
    localparam bcd_t      BCD_ONE   = 4'd1;
    localparam bcd_t      BCD_NINE  = 4'd9;
    localparam bcd_time_t TIME_ZERO = 16'h0000;
    localparam bcd_time_t TIME_ONE  = 16'h0001;

    function automatic bcd_t bcd_clamp(input bcd_t value, input bcd_t digit_max);
        return (value > digit_max) ? digit_max : value;
    endfunction

    // Packing: {min_tens, min_units, sec_tens, sec_units}
    function automatic bcd_time_t clamp_time(input bcd_time_t value,
                                             input bcd_t      sec_tens_max,
                                             input bcd_t      min_tens_max);
        bcd_time_t result;
        result[3:0]   = bcd_clamp(value[3:0],   BCD_NINE);
        result[7:4]   = bcd_clamp(value[7:4],   sec_tens_max);
        result[11:8]  = bcd_clamp(value[11:8],  BCD_NINE);
        result[15:12] = bcd_clamp(value[15:12], min_tens_max);
        return result;
    endfunction

endpackage

// File: rtl/bcd_countdown_timer_digit.sv
// One BCD down-counting digit with clamped load and combinational borrow-out.
// Wraps 0 -> digit_max when a borrow arrives, signalling the next digit.
module bcd_down_digit
    import bcd_countdown_timer_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic borrow_in,
    input  logic load,
    input  bcd_t load_value,
    input  bcd_t digit_max,
    output bcd_t q,
    output logic borrow_out
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= BCD_ZERO;
        end else if (load) begin
            q <= bcd_clamp(load_value, digit_max);
        end else if (borrow_in) begin
            q <= (q == BCD_ZERO) ? digit_max : q - BCD_ONE;
        end
    end

    assign borrow_out = borrow_in && (q == BCD_ZERO);

endmodule

// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown timer: four chained down-digits, load/start/pause FSM, expiry pulse.
// Define COUNTDOWN_AUTO_RELOAD_EN to restart from the last loaded value on expiry.
//
// state    | meaning
// CD_IDLE  | loaded or reset, waiting for start (start ignored at 00:00)
// CD_RUN   | decrementing on tick
// CD_PAUSE | holding value, ticks ignored, start resumes
// CD_DONE  | reached 00:00, only load or rst leaves
module bcd_countdown_timer
    import bcd_countdown_timer_pkg::*;
#(
    parameter int SEC_TENS_MAX = 5,
    parameter int MIN_TENS_MAX = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  load,
    input  logic [TIME_WIDTH-1:0] load_value,
    output logic [TIME_WIDTH-1:0] q,
    output logic                  running,
    output logic                  done,
    output logic                  expired
);

    localparam bcd_t SEC_TENS_LIM = bcd_t'(SEC_TENS_MAX);
    localparam bcd_t MIN_TENS_LIM = bcd_t'(MIN_TENS_MAX);

    cd_state_t state;
    cd_state_t state_next;

    logic      q_zero;
    logic      q_one;
    logic      advance;
    logic      expire_evt;
    logic      reload_hit;
    logic      digit_load;
    bcd_time_t digit_value;
    logic      borrow [NUM_DIGITS+1];

    assign q_zero = (q == TIME_ZERO);
    assign q_one  = (q == TIME_ONE);

    // A tick only counts in RUN when neither load nor pause claims the cycle.
    assign advance    = (state == CD_RUN) && !load && !pause && tick;
    assign expire_evt = advance && q_one;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    bcd_time_t reload_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            reload_q <= TIME_ZERO;
        end else if (load) begin
            reload_q <= clamp_time(load_value, SEC_TENS_LIM, MIN_TENS_LIM);
        end
    end

    assign reload_hit  = expire_evt && (reload_q != TIME_ZERO);
    assign digit_load  = load || reload_hit;
    assign digit_value = load ? load_value : reload_q;
`else
    assign reload_hit  = 1'b0;
    assign digit_load  = load;
    assign digit_value = load_value;
`endif

    // Never borrow out of 00:00 so the chain cannot wrap to the maximum time.
    assign borrow[0] = advance && !q_zero && !reload_hit;

    genvar i;
    generate
        for (i = 0; i < NUM_DIGITS; i++) begin : g_digit
            localparam bcd_t LIMIT = (i == 1) ? SEC_TENS_LIM :
                                     (i == 3) ? MIN_TENS_LIM : BCD_NINE;
            bcd_down_digit u_digit (
                .clk        (clk),
                .rst        (rst),
                .borrow_in  (borrow[i]),
                .load       (digit_load),
                .load_value (digit_value[i*BCD_BIT_WIDTH +: BCD_BIT_WIDTH]),
                .digit_max  (LIMIT),
                .q          (q[i*BCD_BIT_WIDTH +: BCD_BIT_WIDTH]),
                .borrow_out (borrow[i+1])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CD_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (load) begin
            state_next = CD_IDLE;
        end else begin
            case (state)
                CD_IDLE: begin
                    if (start && !q_zero) begin
                        state_next = CD_RUN;
                    end
                end
                CD_RUN: begin
                    if (pause) begin
                        state_next = CD_PAUSE;
                    end else if (expire_evt && !reload_hit) begin
                        state_next = CD_DONE;
                    end
                end
                CD_PAUSE: begin
                    if (start) begin
                        state_next = CD_RUN;
                    end
                end
                CD_DONE: begin
                    state_next = CD_DONE;
                end
                default: begin
                    state_next = CD_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        running = 1'b0;
        done    = 1'b0;
        case (state)
            CD_RUN:  running = 1'b1;
            CD_DONE: done    = 1'b1;
            default: begin
                running = 1'b0;
                done    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            expired <= 1'b0;
        end else begin
            expired <= expire_evt;
        end
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer: directed steps push expected outputs,
// a negedge monitor pops and compares them cycle by cycle.
module tb_bcd_countdown_timer;

    logic        clk;
    logic        rst;
    logic        tick;
    logic        start;
    logic        pause;
    logic        load;
    logic [15:0] load_value;
    logic [15:0] q;
    logic        running;
    logic        done;
    logic        expired;

    typedef struct {
        int          tgt;
        logic [15:0] q;
        logic        running;
        logic        done;
        logic        expired;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc_n = 0;
    int   total = 0;
    int   bad   = 0;

    bcd_countdown_timer dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .start      (start),
        .pause      (pause),
        .load       (load),
        .load_value (load_value),
        .q          (q),
        .running    (running),
        .done       (done),
        .expired    (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].tgt <= cyc_n) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (q !== e.q || running !== e.running || done !== e.done || expired !== e.expired) begin
                bad++;
                $display("FAIL %s: got q=%h run=%b done=%b exp=%b, required q=%h run=%b done=%b exp=%b",
                         e.name, q, running, done, expired, e.q, e.running, e.done, e.expired);
            end
        end
    end

    // ctl = {rst, load, pause, start, tick}
    task automatic step(input logic [4:0] ctl, input logic [15:0] lv,
                        input logic [15:0] eq, input logic er, input logic ed,
                        input logic ee, input string nm);
        exp_t e;
        {rst, load, pause, start, tick} = ctl;
        load_value = lv;
        e.tgt     = cyc_n + 1;
        e.q       = eq;
        e.running = er;
        e.done    = ed;
        e.expired = ee;
        e.name    = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        {rst, load, pause, start, tick} = 5'b0;
        load_value = 16'h0000;
        @(posedge clk);
        #1;

        step(5'b10000, 16'h0000, 16'h0000, 0, 0, 0, "reset");

        step(5'b01000, 16'h0102, 16'h0102, 0, 0, 0, "load_0102");
        step(5'b00001, 16'h0000, 16'h0102, 0, 0, 0, "idle_tick_ignored");
        step(5'b00010, 16'h0000, 16'h0102, 1, 0, 0, "start_0102");
        step(5'b00001, 16'h0000, 16'h0101, 1, 0, 0, "tick_0101");
        step(5'b00001, 16'h0000, 16'h0100, 1, 0, 0, "tick_0100");
        step(5'b00001, 16'h0000, 16'h0059, 1, 0, 0, "tick_borrow_0059");
        step(5'b00000, 16'h0000, 16'h0059, 1, 0, 0, "run_hold");
        step(5'b00011, 16'h0000, 16'h0058, 1, 0, 0, "start_ignored_run");

        step(5'b01000, 16'h0002, 16'h0002, 0, 0, 0, "load_0002");
        step(5'b00010, 16'h0000, 16'h0002, 1, 0, 0, "start_0002");
        step(5'b00001, 16'h0000, 16'h0001, 1, 0, 0, "tick_0001");
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        step(5'b00001, 16'h0000, 16'h0002, 1, 0, 1, "expire_reload");
        step(5'b00001, 16'h0000, 16'h0001, 1, 0, 0, "after_reload_tick");
`else
        step(5'b00001, 16'h0000, 16'h0000, 0, 1, 1, "expire");
        step(5'b00001, 16'h0000, 16'h0000, 0, 1, 0, "done_tick");
        step(5'b00010, 16'h0000, 16'h0000, 0, 1, 0, "done_start");
        step(5'b00100, 16'h0000, 16'h0000, 0, 1, 0, "done_pause");
`endif

        step(5'b01000, 16'h0030, 16'h0030, 0, 0, 0, "load_0030");
        step(5'b00010, 16'h0000, 16'h0030, 1, 0, 0, "start_0030");
        step(5'b00101, 16'h0000, 16'h0030, 0, 0, 0, "pause_with_tick");
        step(5'b00001, 16'h0000, 16'h0030, 0, 0, 0, "pause_tick_ignored");
        step(5'b00010, 16'h0000, 16'h0030, 1, 0, 0, "resume");
        step(5'b00001, 16'h0000, 16'h0029, 1, 0, 0, "tick_0029");
        step(5'b00110, 16'h0000, 16'h0029, 0, 0, 0, "pause_beats_start");
        step(5'b00010, 16'h0000, 16'h0029, 1, 0, 0, "resume2");

        step(5'b01000, 16'h9979, 16'h9959, 0, 0, 0, "clamp_9979");
        step(5'b01000, 16'h00FF, 16'h0059, 0, 0, 0, "clamp_00ff");
        step(5'b01000, 16'hFFFF, 16'h9959, 0, 0, 0, "clamp_ffff");
        step(5'b01000, 16'h1000, 16'h1000, 0, 0, 0, "load_1000");
        step(5'b00010, 16'h0000, 16'h1000, 1, 0, 0, "start_1000");
        step(5'b00001, 16'h0000, 16'h0959, 1, 0, 0, "borrow_chain_0959");
        step(5'b01010, 16'h0010, 16'h0010, 0, 0, 0, "load_beats_start");
        step(5'b01000, 16'h0000, 16'h0000, 0, 0, 0, "load_zero");
        step(5'b00010, 16'h0000, 16'h0000, 0, 0, 0, "start_at_zero");
        step(5'b00011, 16'h0000, 16'h0000, 0, 0, 0, "start_tick_at_zero");

        step(5'b01000, 16'h0046, 16'h0046, 0, 0, 0, "load_0046");
        step(5'b00010, 16'h0000, 16'h0046, 1, 0, 0, "start_0046");
        step(5'b00001, 16'h0000, 16'h0045, 1, 0, 0, "tick_0045");
        step(5'b10001, 16'h0000, 16'h0000, 0, 0, 0, "reset_mid_run");
        step(5'b11000, 16'h0099, 16'h0000, 0, 0, 0, "reset_beats_load");

        step(5'b01000, 16'h0001, 16'h0001, 0, 0, 0, "load_0001");
        step(5'b00010, 16'h0000, 16'h0001, 1, 0, 0, "start_0001");
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        step(5'b00001, 16'h0000, 16'h0001, 1, 0, 1, "expire_reload_0001");
        step(5'b00001, 16'h0000, 16'h0001, 1, 0, 1, "expire_reload_again");
`else
        step(5'b00001, 16'h0000, 16'h0000, 0, 1, 1, "expire_0001");
        step(5'b00001, 16'h0000, 16'h0000, 0, 1, 0, "done_hold");
`endif
        step(5'b01000, 16'h0005, 16'h0005, 0, 0, 0, "load_leaves_state");
        step(5'b00000, 16'h0000, 16'h0005, 0, 0, 0, "final_idle");

        for (int k = 0; k < 20; k++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
